// File: rtl/toy_bus_arb_node_ack_rr2.sv
// 2:1 round-robin ack arbiter node.
// Merges two ack sources into a 2-entry registered output buffer.
module toy_bus_arb_node_ack_rr2 #(
  parameter int DATA_W = 256,
  parameter int SB_W   = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_vld,
  output logic              in0_rdy,
  input  logic              in0_opcode,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [SB_W-1:0]   in0_sideband,
  input  logic [ID_W-1:0]   in0_src_id,
  input  logic [ID_W-1:0]   in0_tgt_id,
  input  logic              in1_vld,
  output logic              in1_rdy,
  input  logic              in1_opcode,
  input  logic [DATA_W-1:0] in1_data,
  input  logic [SB_W-1:0]   in1_sideband,
  input  logic [ID_W-1:0]   in1_src_id,
  input  logic [ID_W-1:0]   in1_tgt_id,
  output logic              out0_vld,
  input  logic              out0_rdy,
  output logic              out0_opcode,
  output logic [DATA_W-1:0] out0_data,
  output logic [SB_W-1:0]   out0_sideband,
  output logic [ID_W-1:0]   out0_src_id,
  output logic [ID_W-1:0]   out0_tgt_id
);

  logic [1:0]        r_cnt;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic              r_last_gnt;

  logic              r_opc [2];
  logic [DATA_W-1:0] r_data [2];
  logic [SB_W-1:0]   r_sb [2];
  logic [ID_W-1:0]   r_src [2];
  logic [ID_W-1:0]   r_tgt [2];

  logic              w_can_acc;
  logic              w_pick;
  logic              w_push;
  logic              w_pop;

  logic              w_opc;
  logic [DATA_W-1:0] w_data;
  logic [SB_W-1:0]   w_sb;
  logic [ID_W-1:0]   w_src;
  logic [ID_W-1:0]   w_tgt;

  // Acceptance depends on buffer occupancy only, never on out0_rdy.
  assign w_can_acc = (r_cnt != 2'd2);

  // Round-robin pick; with no requester the idle pick shows priority.
  always_comb begin
    w_pick = ~r_last_gnt;
    if (in0_vld && !in1_vld)
      w_pick = 1'b0;
    else if (in1_vld && !in0_vld)
      w_pick = 1'b1;
  end

  assign in0_rdy = w_can_acc && !w_pick;
  assign in1_rdy = w_can_acc && w_pick;

  assign w_push = w_pick ? (in1_vld && in1_rdy)
                         : (in0_vld && in0_rdy);
  assign w_pop  = out0_vld && out0_rdy;

  // Payload of the granted source.
  always_comb begin
    w_opc  = in0_opcode;
    w_data = in0_data;
    w_sb   = in0_sideband;
    w_src  = in0_src_id;
    w_tgt  = in0_tgt_id;
    if (w_pick) begin
      w_opc  = in1_opcode;
      w_data = in1_data;
      w_sb   = in1_sideband;
      w_src  = in1_src_id;
      w_tgt  = in1_tgt_id;
    end
  end

  // Pointers, occupancy and round-robin state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_last_gnt <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= ~r_wr_ptr;
        r_last_gnt <= w_pick;
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 2'd1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 2'd1;
    end
  end

  // Buffer entries; written at wr_ptr on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_opc[i]  <= 1'b0;
        r_data[i] <= '0;
        r_sb[i]   <= '0;
        r_src[i]  <= '0;
        r_tgt[i]  <= '0;
      end
    end else if (w_push) begin
      r_opc[r_wr_ptr]  <= w_opc;
      r_data[r_wr_ptr] <= w_data;
      r_sb[r_wr_ptr]   <= w_sb;
      r_src[r_wr_ptr]  <= w_src;
      r_tgt[r_wr_ptr]  <= w_tgt;
    end
  end

  assign out0_vld      = (r_cnt != 2'd0);
  assign out0_opcode   = r_opc[r_rd_ptr];
  assign out0_data     = r_data[r_rd_ptr];
  assign out0_sideband = r_sb[r_rd_ptr];
  assign out0_src_id   = r_src[r_rd_ptr];
  assign out0_tgt_id   = r_tgt[r_rd_ptr];

endmodule

// File: tb/tb_toy_bus_arb_node_ack_rr2.sv
// Bench for the 2:1 round-robin ack arbiter node.
// Directed steps with a beat scoreboard on the output.
module tb_toy_bus_arb_node_ack_rr2;

  localparam int DATA_W = 256;
  localparam int SB_W   = 32;
  localparam int ID_W   = 4;
  localparam int BW     = 1 + DATA_W + SB_W + 2 * ID_W;

  logic              clk;
  logic              rst;
  logic              in0_vld, in0_rdy, in0_opcode;
  logic [DATA_W-1:0] in0_data;
  logic [SB_W-1:0]   in0_sideband;
  logic [ID_W-1:0]   in0_src_id, in0_tgt_id;
  logic              in1_vld, in1_rdy, in1_opcode;
  logic [DATA_W-1:0] in1_data;
  logic [SB_W-1:0]   in1_sideband;
  logic [ID_W-1:0]   in1_src_id, in1_tgt_id;
  logic              out0_vld, out0_rdy, out0_opcode;
  logic [DATA_W-1:0] out0_data;
  logic [SB_W-1:0]   out0_sideband;
  logic [ID_W-1:0]   out0_src_id, out0_tgt_id;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] sb[$];

  toy_bus_arb_node_ack_rr2 dut (
    .clk(clk), .rst(rst),
    .in0_vld(in0_vld), .in0_rdy(in0_rdy),
    .in0_opcode(in0_opcode), .in0_data(in0_data),
    .in0_sideband(in0_sideband),
    .in0_src_id(in0_src_id), .in0_tgt_id(in0_tgt_id),
    .in1_vld(in1_vld), .in1_rdy(in1_rdy),
    .in1_opcode(in1_opcode), .in1_data(in1_data),
    .in1_sideband(in1_sideband),
    .in1_src_id(in1_src_id), .in1_tgt_id(in1_tgt_id),
    .out0_vld(out0_vld), .out0_rdy(out0_rdy),
    .out0_opcode(out0_opcode), .out0_data(out0_data),
    .out0_sideband(out0_sideband),
    .out0_src_id(out0_src_id), .out0_tgt_id(out0_tgt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input int d, input int s);
    in0_vld      = v;
    in0_data     = DATA_W'(d);
    in0_opcode   = in0_data[0];
    in0_sideband = in0_data[SB_W-1:0] ^ 32'hA5A5_5A5A;
    in0_src_id   = ID_W'(s);
    in0_tgt_id   = ~in0_src_id;
  endtask

  task automatic drv1(input logic v, input int d, input int s);
    in1_vld      = v;
    in1_data     = DATA_W'(d);
    in1_opcode   = in1_data[0];
    in1_sideband = in1_data[SB_W-1:0] ^ 32'h0F0F_F0F0;
    in1_src_id   = ID_W'(s);
    in1_tgt_id   = ~in1_src_id;
  endtask

  // Scoreboard: pop/compare output beats, then record accepted inputs.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out0_vld && out0_rdy) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_beat", {out0_opcode, out0_data,
              out0_sideband, out0_src_id, out0_tgt_id}, '0);
        end else begin
          chk("sb_beat", {out0_opcode, out0_data, out0_sideband,
              out0_src_id, out0_tgt_id}, sb.pop_front());
        end
      end
      if (in0_vld && in0_rdy)
        sb.push_back({in0_opcode, in0_data, in0_sideband,
                      in0_src_id, in0_tgt_id});
      if (in1_vld && in1_rdy)
        sb.push_back({in1_opcode, in1_data, in1_sideband,
                      in1_src_id, in1_tgt_id});
    end
  end

  initial begin
    rst = 1'b1;
    out0_rdy = 1'b0;
    drv0(1'b0, 0, 0);
    drv1(1'b0, 0, 0);
    cyc();
    cyc();
    rst = 1'b0;
    // 1: reset state
    chk("rst_out_vld", BW'(out0_vld), BW'(0));
    chk("rst_out_data", BW'(out0_data), BW'(0));
    chk("rst_in0_rdy", BW'(in0_rdy), BW'(1));
    chk("rst_in1_rdy", BW'(in1_rdy), BW'(0));

    // 2: in0 back-to-back stream
    out0_rdy = 1'b1;
    drv0(1'b1, 1, 3);
    cyc();
    chk("lat_out_vld", BW'(out0_vld), BW'(1));
    chk("lat_out_data", BW'(out0_data), BW'(1));
    drv0(1'b1, 2, 3);
    cyc();
    chk("s2_data2", BW'(out0_data), BW'(2));
    drv0(1'b1, 3, 3);
    cyc();
    chk("s2_data3", BW'(out0_data), BW'(3));
    drv0(1'b0, 0, 0);
    cyc();
    cyc();
    chk("s2_drained", BW'(out0_vld), BW'(0));

    // 3: fairness after reset, in0 first
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drv0(1'b1, 'h100 + 2 * i, 0);
      drv1(1'b1, 'h101 + 2 * i, 1);
      #1;
      chk("rr_in0_rdy", BW'(in0_rdy), BW'(i % 2 == 0));
      chk("rr_in1_rdy", BW'(in1_rdy), BW'(i % 2 == 1));
      cyc();
      chk("rr_out_src", BW'(out0_src_id), BW'(i % 2));
    end
    drv0(1'b0, 0, 0);
    drv1(1'b0, 0, 0);
    cyc();
    cyc();

    // 4: backpressure fills the buffer
    out0_rdy = 1'b0;
    drv1(1'b1, 'hA, 5);
    cyc();
    drv1(1'b1, 'hB, 5);
    cyc();
    drv1(1'b1, 'hC, 5);
    #1;
    chk("full_in1_rdy", BW'(in1_rdy), BW'(0));
    chk("full_out_vld", BW'(out0_vld), BW'(1));
    cyc();
    chk("stall_head_a", BW'(out0_data), BW'('hA));
    cyc();
    chk("stall_head_b", BW'(out0_data), BW'('hA));
    out0_rdy = 1'b1;
    cyc();
    chk("drain_head_b", BW'(out0_data), BW'('hB));
    cyc();
    chk("drain_head_c", BW'(out0_data), BW'('hC));
    drv1(1'b0, 0, 0);
    cyc();
    chk("s4_drained", BW'(out0_vld), BW'(0));

    // 5: push and pop together at count 1
    out0_rdy = 1'b0;
    drv0(1'b1, 'h51, 2);
    cyc();
    out0_rdy = 1'b1;
    drv0(1'b1, 'h52, 2);
    cyc();
    drv0(1'b0, 0, 0);
    chk("pp_out_vld", BW'(out0_vld), BW'(1));
    chk("pp_out_data", BW'(out0_data), BW'('h52));
    #1;
    chk("pp_can_acc", BW'(in0_rdy | in1_rdy), BW'(1));
    cyc();
    chk("pp_count1", BW'(out0_vld), BW'(0));

    // 6: reset while full discards buffered beats
    out0_rdy = 1'b0;
    drv0(1'b1, 'h61, 4);
    cyc();
    drv0(1'b1, 'h62, 4);
    cyc();
    drv0(1'b0, 0, 0);
    #1;
    chk("s6_full", BW'(in0_rdy | in1_rdy), BW'(0));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("s6_out_vld", BW'(out0_vld), BW'(0));
    chk("s6_out_data", BW'(out0_data), BW'(0));
    chk("s6_in0_rdy", BW'(in0_rdy), BW'(1));
    chk("s6_in1_rdy", BW'(in1_rdy), BW'(0));
    out0_rdy = 1'b1;
    cyc();
    cyc();
    chk("s6_no_emit", BW'(out0_vld), BW'(0));
    chk("sb_empty", BW'(sb.size()), BW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
